// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// error read-back value, default geometry and the range check.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_ACK  = S_ACK
  } dmem_state_e;

  localparam logic [15:0] DMEM_ERR_DATA = 16'hFFFF;

  // An address is in range when every bit above the implemented width is 0;
  // out-of-range addresses are flagged rather than aliased onto the store.
  function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/ack bus between the processor (master) and the data-memory
// responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 16
) ();

  logic              req_pi;
  logic              we_pi;
  logic [15:0]       addr_pi;
  logic [DATA_W-1:0] wdata_pi;
  logic              ack_po;
  logic [DATA_W-1:0] rdata_po;
  logic              err_po;
  logic              busy_po;

  modport master (
    output req_pi, we_pi, addr_pi, wdata_pi,
    input  ack_po, rdata_po, err_po, busy_po
  );

  modport slave (
    input  req_pi, we_pi, addr_pi, wdata_pi,
    output ack_po, rdata_po, err_po, busy_po
  );

endinterface

// File: rtl/dmem_array.sv
// Data store: synchronous write, combinational read, whole-array clear on
// reset. Everything holds while the cycle enable is low.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_pi,
  input  logic              reset_n_pi,
  input  logic              clk_en_pi,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: reset clears every word regardless of the enable.
  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clk_en_pi && we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the processor data-memory port. Captures a request,
// counts out WAIT_CYCLES wait states, then commits the access and pulses
// ack for one enabled cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk_pi,
  input  logic               reset_n_pi,
  input  logic               clk_en_pi,
  dmem_responder_if.slave    bus
);

  localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [DATA_W-1:0] ERR_DATA  = DATA_W'(DMEM_ERR_DATA);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // The access performed on the edge that enters ACK. With zero wait
  // states that edge is the capture edge, so the live bus fields are used.
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic              enter_ack;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_pi     (clk_pi),
    .reset_n_pi (reset_n_pi),
    .clk_en_pi  (clk_en_pi),
    .we         (mem_we),
    .addr       (acc_addr[ADDR_W-1:0]),
    .wdata      (acc_wdata),
    .rdata      (mem_rdata)
  );

  // Select which copy of the request fields drives the memory this cycle.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_we    = bus.we_pi;
      acc_addr  = bus.addr_pi;
      acc_wdata = bus.wdata_pi;
    end
    acc_in_range = addr_in_range(acc_addr, ADDR_W);
  end

  // Next-state, wait counter, request latch and ack/err/rdata updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    enter_ack = 1'b0;

    if (clk_en_pi) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_pi) begin
            we_d    = bus.we_pi;
            addr_d  = bus.addr_pi;
            wdata_d = bus.wdata_pi;
            cnt_d   = WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              state_d   = ST_ACK;
              enter_ack = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (enter_ack) begin
        ack_d = 1'b1;
        if (!acc_in_range) begin
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          err_d = 1'b0;
          if (!acc_we) begin
            rdata_d = mem_rdata;
          end
        end
      end
    end

    mem_we = enter_ack && acc_we && acc_in_range;
  end

  // Register update; reset aborts any transaction in flight.
  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack_po   = ack_q;
  assign bus.err_po   = err_q;
  assign bus.rdata_po = rdata_q;
  assign bus.busy_po  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance for directed/random
// transactions and a WAIT_CYCLES=0 instance for back-to-back requests.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;

  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(16)) b2 ();
  dmem_responder_if #(.DATA_W(16)) b0 ();

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) u_dut2 (
    .clk_pi     (clk),
    .reset_n_pi (rst_n),
    .clk_en_pi  (clk_en),
    .bus        (b2)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk_pi     (clk),
    .reset_n_pi (rst_n),
    .clk_en_pi  (clk_en),
    .bus        (b0)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model of the WAIT_CYCLES=2 instance
  logic [15:0] mdl_mem [256];
  logic [15:0] mdl_rd;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h0000;
    mdl_rd = 16'h0000;
  endfunction

  function automatic void mdl_apply(input bit we, input logic [15:0] a, input logic [15:0] d,
                                    output logic [15:0] rd, output bit er);
    if (a > 16'h00FF) begin
      er     = 1'b1;
      mdl_rd = 16'hFFFF;
    end else begin
      er = 1'b0;
      if (we) mdl_mem[a[7:0]] = d;
      else    mdl_rd = mdl_mem[a[7:0]];
    end
    rd = mdl_rd;
  endfunction

  // One request on the WAIT_CYCLES=2 instance; fields are scrambled after
  // capture, and an optional stall is inserted one edge after capture.
  task automatic txn(input bit we, input logic [15:0] a, input logic [15:0] d,
                     input int stall_len,
                     output logic [15:0] rd, output bit er, output int edges);
    bit got;
    @(negedge clk);
    b2.req_pi   = 1'b1;
    b2.we_pi    = we;
    b2.addr_pi  = a;
    b2.wdata_pi = d;
    edges = 0;
    got   = 1'b0;
    while (edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (b2.ack_po) begin
        got = 1'b1;
        break;
      end
      chk("busy_wait", b2.busy_po, 1);
      if (edges == 1) begin
        b2.we_pi    = ~we;
        b2.addr_pi  = 16'($urandom);
        b2.wdata_pi = 16'($urandom);
      end
      if (edges == 1 && stall_len > 0) begin
        clk_en = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          edges++;
          chk("busy_stall", b2.busy_po, 1);
          chk("ack_stall", b2.ack_po, 0);
        end
        clk_en = 1'b1;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    rd = b2.rdata_po;
    er = b2.err_po;
    b2.req_pi = 1'b0;
    @(posedge clk); #1;
    chk("ack_clear", b2.ack_po, 0);
    chk("busy_clear", b2.busy_po, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, mrd;
    bit          er, mer;
    int          edges;
    bit          bw  [5];
    logic [15:0] ba  [5];
    logic [15:0] bd  [5];
    logic [15:0] brd [5];
    bit          ber [5];

    tbl[0] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b0, 16'h0100, 16'h0000, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b1, 16'h0100, 16'h1234, 16'hFFFF, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
    tbl[7] = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
    tbl[8] = '{1'b0, 16'h8000, 16'h0000, 16'hFFFF, 1'b1};
    tbl[9] = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};

    rst_n  = 1'b0;
    clk_en = 1'b1;
    b2.req_pi = 1'b0; b2.we_pi = 1'b0; b2.addr_pi = '0; b2.wdata_pi = '0;
    b0.req_pi = 1'b0; b0.we_pi = 1'b0; b0.addr_pi = '0; b0.wdata_pi = '0;
    mdl_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ack",   b2.ack_po,   0);
    chk("rst_busy",  b2.busy_po,  0);
    chk("rst_err",   b2.err_po,   0);
    chk("rst_rdata", b2.rdata_po, 16'h0000);
    chk("rst_ack0",  b0.ack_po,   0);
    chk("rst_busy0", b0.busy_po,  0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, rd, er, edges);
      mdl_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, mrd, mer);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
      chk($sformatf("tbl%0d_lat", i), edges, 3);
    end

    // Stall of 4 enabled-low cycles during WAIT
    txn(1'b1, 16'h0020, 16'h1111, 4, rd, er, edges);
    mdl_apply(1'b1, 16'h0020, 16'h1111, mrd, mer);
    chk("stall_lat", edges, 7);
    chk("stall_err", er, 0);
    txn(1'b0, 16'h0020, 16'h0000, 0, rd, er, edges);
    mdl_apply(1'b0, 16'h0020, 16'h0000, mrd, mer);
    chk("stall_rd", rd, 16'h1111);

    // Reset during WAIT aborts the store and clears the store
    @(negedge clk);
    b2.req_pi = 1'b1; b2.we_pi = 1'b1; b2.addr_pi = 16'h0007; b2.wdata_pi = 16'hAAAA;
    @(posedge clk); #1;
    chk("rstw_busy", b2.busy_po, 1);
    rst_n = 1'b0;
    b2.req_pi = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rstw_noack", b2.ack_po, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstw_idle_ack", b2.ack_po, 0);
    end
    chk("rstw_rdata", b2.rdata_po, 16'h0000);
    txn(1'b0, 16'h0007, 16'h0000, 0, rd, er, edges);
    mdl_apply(1'b0, 16'h0007, 16'h0000, mrd, mer);
    chk("rstw_load", rd, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      bit          we;
      logic [15:0] a, d;
      we = 1'($urandom);
      a  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      txn(we, a, d, 0, rd, er, edges);
      mdl_apply(we, a, d, mrd, mer);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), er, mer);
      chk($sformatf("rnd%0d_lat", i), edges, 3);
    end

    // Zero-wait instance with req held high across consecutive accesses
    bw[0] = 1'b1; ba[0] = 16'h0011; bd[0] = 16'h0A0A; brd[0] = 16'h0000; ber[0] = 1'b0;
    bw[1] = 1'b1; ba[1] = 16'h0022; bd[1] = 16'h0B0B; brd[1] = 16'h0000; ber[1] = 1'b0;
    bw[2] = 1'b0; ba[2] = 16'h0011; bd[2] = 16'h0000; brd[2] = 16'h0A0A; ber[2] = 1'b0;
    bw[3] = 1'b0; ba[3] = 16'h0022; bd[3] = 16'h0000; brd[3] = 16'h0B0B; ber[3] = 1'b0;
    bw[4] = 1'b0; ba[4] = 16'h0300; bd[4] = 16'h0000; brd[4] = 16'hFFFF; ber[4] = 1'b1;
    begin
      int t, prev;
      bit got;
      @(negedge clk);
      b0.req_pi = 1'b1; b0.we_pi = bw[0]; b0.addr_pi = ba[0]; b0.wdata_pi = bd[0];
      t = 0; prev = 0;
      for (int k = 0; k < 5; k++) begin
        got = 1'b0;
        for (int w = 0; w < 10; w++) begin
          @(posedge clk); #1;
          t++;
          if (b0.ack_po) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) chk($sformatf("b2b%0d_timeout", k), 0, 1);
        chk($sformatf("b2b%0d_gap", k), t - prev, (k == 0) ? 1 : 2);
        chk($sformatf("b2b%0d_rdata", k), b0.rdata_po, brd[k]);
        chk($sformatf("b2b%0d_err", k), b0.err_po, ber[k]);
        prev = t;
        if (k < 4) begin
          b0.we_pi = bw[k+1]; b0.addr_pi = ba[k+1]; b0.wdata_pi = bd[k+1];
        end else begin
          b0.req_pi = 1'b0;
        end
      end
      @(posedge clk); #1;
      chk("b2b_ack_clear", b0.ack_po, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the processor's data-memory port. It holds a 256×16 data store and answers load/store requests over a registered req/ack handshake. It inserts a fixed, parameterised number of wait states before answering. It sits between the processor top and the data store, replacing the zero-latency combinational path, so later multi-cycle memories can be modelled without changing the processor side.

## Interface
- ADDR_W, 8: implemented word-address bits (depth = 2**ADDR_W)
- DATA_W, 16: word width
- WAIT_CYCLES, 2: wait states between request capture and ack; legal range 0–15

- clk_pi  in  1  system clock; all logic on rising edge
- reset_n_pi  in  1  synchronous, active-low reset
- clk_en_pi  in  1  cycle enable; when low all state, including memory, holds
- req_pi  in  1  request valid; requester holds it, with stable fields, until ack
- we_pi  in  1  1 = store, 0 = load
- addr_pi  in  16  word address
- wdata_pi  in  DATA_W  store data
- ack_po  out  1  one-cycle completion pulse
- rdata_po  out  DATA_W  load data; valid while ack_po is high, held until the next ack
- err_po  out  1  out-of-range flag; qualified by ack_po
- busy_po  out  1  high in the WAIT and ACK states

## Operation
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an enabled edge with req_pi=1, latch we/addr/wdata.
  - Load wait counter with WAIT_CYCLES-1.
  - Go to WAIT, or go directly to ACK if WAIT_CYCLES=0.
- WAIT: decrement the counter on each enabled edge; at 0 go to ACK.
- Entering ACK (registered on the same edge):
  - ack_po=1.
  - In-range store: mem[addr] ← wdata; rdata_po unchanged.
  - In-range load: rdata_po ← mem[addr].
  - Out of range (addr_pi[15:ADDR_W] ≠ 0): err_po=1, no write, rdata_po ← 16'hFFFF.
- ACK lasts exactly one cycle, then returns to IDLE. ack_po and err_po clear on the exit edge.
- Back-to-back operation: a request still high in IDLE is treated as a new transaction. The requester must drop req_pi in the cycle after ack unless it intends a new access.
- Request field changes during WAIT are ignored; the latched copy is used.
- Load after store to the same address returns the stored value. No forwarding is needed because the write commits at the earlier ack.

## Timing
- Request first sampled at enabled edge N → ack_po high during cycle N+1+WAIT_CYCLES, counted in enabled edges.
- Store visible to any load captured at or after the ack edge.
- clk_en_pi low: state, counter and outputs frozen. ack_po stays high if the block is frozen in ACK, and the pulse is counted per enabled cycle.
- Reset (reset_n_pi=0 at an edge; clk_en_pi ignored during reset):
  - State IDLE, counter 0.
  - ack_po=0, err_po=0, busy_po=0, rdata_po=0.
  - All memory words cleared to 0.
- Reset mid-transaction aborts it: no write, no ack. The requester must re-issue.
- Address wrap: none; out-of-range addresses are flagged, not aliased.

## Structure
- Shared package dmem_pkg:
  - State encoding localparams (S_IDLE=2'd0, S_WAIT=2'd1, S_ACK=2'd2).
  - DMEM_ERR_DATA=16'hFFFF.
  - Default ADDR_W/DATA_W.
- Sub-module dmem_array: the storage. Synchronous write, combinational read, synchronous clear on reset, gated by clk_en_pi.
- FSM, wait counter and output registers live in dmem_responder.

## Test plan
- Reset then idle: reset_n_pi=0 for 2 cycles, then release → ack_po=0, busy_po=0, rdata_po=16'h0000; a load of addr 16'h0010 returns 16'h0000.
- Store/load, WAIT_CYCLES=2: store 16'hBEEF to 16'h0005 at edge N → ack at N+3. Then load 16'h0005 → ack 3 cycles later, rdata_po=16'hBEEF, err_po=0.
- Out of range: load 16'h0100 → ack with err_po=1, rdata_po=16'hFFFF. A store of 16'h1234 to 16'h0100 leaves mem[16'h00] unchanged.
- Stall: clk_en_pi low for 4 cycles mid-WAIT → ack delayed by exactly 4 cycles; busy_po held high throughout.
- Reset mid-WAIT: store 16'hAAAA to 16'h0007, assert reset before ack → no ack; a later load of 16'h0007 returns 16'h0000.
- WAIT_CYCLES=0 back-to-back: req_pi held high across 3 loads → ack every 2nd cycle, each with correct data.
